mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single backing data memory between the instruction-side and data-side memory management units. It sits between both MMUs' miss/write-back paths and the memory array. It serialises their accesses into one memory transaction at a time and holds the memory strobes for a fixed latency. It returns read data with a one-cycle acknowledge pulse to the requester that was granted.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: state encodings,
// requester IDs and the full byte-select mask.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [3:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between instruction and data requesters.
// ARB_ROUND_ROBIN_EN makes ties alternate using last_grant; otherwise data side wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, favour whichever side did not win last time
      grant_id = ~last_grant;
`else
      grant_id = REQ_D;
`endif
    end else if (d_req) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-side and D-side MMU accesses onto one memory port with a fixed strobe latency.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state;
  logic [3:0] cnt;
  logic       req_id;
  logic       grant_valid;
  logic       grant_id;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign busy = (state != IDLE);

  // The mem_* outputs are the latch registers themselves; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_id    <= REQ_I;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= REQ_I;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            req_id <= grant_id;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_id;
`endif
            if (grant_id == REQ_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
              mem_ren   <= ~d_wen;
              mem_wen   <= d_wen;
            end else begin
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_be    <= BE_FULL;
              mem_ren   <= 1'b1;
              mem_wen   <= 1'b0;
            end
            cnt   <= 4'(MEM_LAT - 1);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            if (req_id == REQ_D) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2 instance plus a MEM_LAT=1 instance).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_ack, d_ack, mem_ren, mem_wen, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        l1_i_req, l1_d_req;
  logic [31:0] l1_d_addr;
  logic        l1_i_ack, l1_d_ack, l1_mem_ren, l1_mem_wen, l1_busy;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [3:0]  l1_mem_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_rdata    = mem_model(mem_addr);
  assign l1_mem_rdata = mem_model(l1_mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(32'h0), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_wen(1'b0), .d_addr(l1_d_addr), .d_wdata(32'h0), .d_be(4'hF),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_ren(l1_mem_ren), .mem_wen(l1_mem_wen), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_be(l1_mem_be), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_req = 0; d_req = 0; d_wen = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    l1_i_req = 0; l1_d_req = 0; l1_d_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({mem_ren, mem_wen} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b expected 00", {mem_ren, mem_wen}); end
    checks++; if ({i_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks: got %b expected 00", {i_ack, d_ack}); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin failures++; $display("FAIL reset_latches: got %h expected 0", {mem_addr, mem_wdata, mem_be}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
  endtask

  task automatic test_tie;
    for (int pair = 0; pair < 2; pair++) begin
      int dk = 0;
      int ik = 0;
      i_addr = 32'h300; d_addr = 32'h400; d_wen = 0; d_be = 4'hF;
      i_req = 1; d_req = 1;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (d_ack) begin dk = k; d_req = 0; end
        if (i_ack) begin ik = k; i_req = 0; end
      end
      i_req = 0; d_req = 0;
      checks++; if (dk !== 3) begin failures++; $display("FAIL tie%0d_d_first: d_ack at %0d expected 3", pair, dk); end
      checks++; if (ik !== 7) begin failures++; $display("FAIL tie%0d_i_second: i_ack at %0d expected 7", pair, ik); end
    end
  endtask

  task automatic test_d_read;
    int ren_cnt = 0, ack_k = 0, acks = 0, iacks = 0;
    logic [31:0] addr_seen = 0, rd = 0;
    d_addr = 32'h100; d_wen = 0; d_be = 4'hF; d_req = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_ren) begin ren_cnt++; addr_seen = mem_addr; end
      if (i_ack) iacks++;
      if (d_ack) begin acks++; ack_k = k; rd = d_rdata; d_req = 0; end
    end
    checks++; if (ren_cnt !== 2) begin failures++; $display("FAIL rd_strobe_len: got %0d expected 2", ren_cnt); end
    checks++; if (addr_seen !== 32'h100) begin failures++; $display("FAIL rd_addr: got %h expected 00000100", addr_seen); end
    checks++; if (ack_k !== 3 || acks !== 1) begin failures++; $display("FAIL rd_ack: at %0d count %0d expected at 3 count 1", ack_k, acks); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (iacks !== 0) begin failures++; $display("FAIL rd_no_i_ack: got %0d expected 0", iacks); end
  endtask

  task automatic test_d_write;
    int wen_cnt = 0, ren_cnt = 0, acks = 0;
    logic [3:0]  be_seen = 0;
    logic [31:0] wd_seen = 0;
    d_addr = 32'h200; d_wen = 1; d_be = 4'b0011; d_wdata = 32'h1234_5678; d_req = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_wen) begin wen_cnt++; be_seen = mem_be; wd_seen = mem_wdata; end
      if (mem_ren) ren_cnt++;
      if (d_ack) begin acks++; d_req = 0; end
    end
    d_wen = 0;
    checks++; if (wen_cnt !== 2) begin failures++; $display("FAIL wr_strobe_len: got %0d expected 2", wen_cnt); end
    checks++; if (be_seen !== 4'b0011 || wd_seen !== 32'h1234_5678) begin failures++; $display("FAIL wr_be_data: got %b %h expected 0011 12345678", be_seen, wd_seen); end
    checks++; if (ren_cnt !== 0) begin failures++; $display("FAIL wr_no_ren: got %0d expected 0", ren_cnt); end
    checks++; if (acks !== 1) begin failures++; $display("FAIL wr_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_busy_arrival;
    int ik = 0;
    logic [31:0] a2, a4, a5, ird;
    a2 = 0; a4 = 0; a5 = 0; ird = 0;
    d_addr = 32'h500; d_wen = 0; d_be = 4'hF; d_req = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin i_addr = 32'h600; i_req = 1; end
      if (k == 2) a2 = mem_addr;
      if (k == 4) a4 = mem_addr;
      if (k == 5) a5 = mem_ren ? mem_addr : 32'hFFFF_FFFF;
      if (d_ack) d_req = 0;
      if (i_ack) begin ik = k; ird = i_rdata; i_req = 0; end
    end
    checks++; if (a2 !== 32'h500 || a4 !== 32'h500) begin failures++; $display("FAIL busy_addr_stable: got %h %h expected 00000500", a2, a4); end
    checks++; if (a5 !== 32'h600) begin failures++; $display("FAIL busy_i_grant_addr: got %h expected 00000600", a5); end
    checks++; if (ik !== 7 || ird !== mem_model(32'h600)) begin failures++; $display("FAIL busy_i_ack: at %0d data %h expected 7 %h", ik, ird, mem_model(32'h600)); end
  endtask

  task automatic test_reset_abort;
    int acks = 0, ack_k = 0;
    logic [31:0] rd = 0;
    d_addr = 32'h700; d_wen = 0; d_be = 4'hF; d_req = 1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({mem_ren, mem_wen, busy} !== 3'b000) begin failures++; $display("FAIL abort_async: ren/wen/busy %b expected 000", {mem_ren, mem_wen, busy}); end
    d_req = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (d_ack || i_ack) acks++;
    end
    checks++; if (acks !== 0 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_ack: acks %0d busy %b expected 0 0", acks, busy); end
    d_addr = 32'h104; d_req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (d_ack) begin ack_k = k; rd = d_rdata; d_req = 0; end
    end
    checks++; if (ack_k !== 3 || rd !== mem_model(32'h104)) begin failures++; $display("FAIL abort_recover: at %0d data %h expected 3 %h", ack_k, rd, mem_model(32'h104)); end
  endtask

  task automatic test_lat1;
    int ren_cnt = 0, ack1 = 0, ack2 = 0;
    logic ren_k2 = 1'b1;
    logic [31:0] rd = 0;
    l1_d_addr = 32'h40; l1_d_req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (l1_mem_ren) ren_cnt++;
      if (k == 2) ren_k2 = l1_mem_ren;
      if (l1_d_ack) begin
        if (ack1 == 0) begin ack1 = k; rd = l1_d_rdata; end
        else if (ack2 == 0) ack2 = k;
      end
    end
    l1_d_req = 0;
    repeat (4) tick();
    checks++; if (ren_k2 !== 1'b0 || ren_cnt !== 2) begin failures++; $display("FAIL lat1_strobe: k2 %b count %0d expected 0 2", ren_k2, ren_cnt); end
    checks++; if (ack1 !== 2 || ack2 !== 5) begin failures++; $display("FAIL lat1_ack_spacing: %0d %0d expected 2 5", ack1, ack2); end
    checks++; if (rd !== mem_model(32'h40)) begin failures++; $display("FAIL lat1_data: got %h expected %h", rd, mem_model(32'h40)); end
  endtask

  initial begin
    test_reset();
    test_tie();
    repeat (2) tick();
    test_d_read();
    repeat (2) tick();
    test_d_write();
    repeat (2) tick();
    test_busy_arrival();
    repeat (2) tick();
    test_reset_abort();
    repeat (2) tick();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
